// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Holds the queue entry layout and the optional trap FSM encoding.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int          FETCH_DEPTH_DEFAULT = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head is visible the cycle after push.
// Caller never pushes when full without popping; flush+push leaves only the pushed entry.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_dat,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t            mem_q [DEPTH];
  fetch_entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Restart from slot 0 so the surviving entry is the new head.
      rd_ptr_d = '0;
      if (push) begin
        mem_d[0] = push_dat;
        wr_ptr_d = PTR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        wr_ptr_d = '0;
        count_d  = '0;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// PC owner and fetch queue between combinational imem and IF/ID; head appears 1 cycle after fetch.
// Stalls fetch when the queue is full and unpopped; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect FAULT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redir_pc;
  logic             redir_bad;
  logic             running;
  logic             push, pop, flush;
  fetch_entry_t     push_dat;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_t state_q, state_d;

  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign running   = (state_q == RUN);
  assign fault     = (state_q == FAULT);

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = redir_bad ? FAULT : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign redir_pc  = redirect_pc & ~32'h0000_0003;
  assign redir_bad = 1'b0;
  assign running   = 1'b1;
  assign fault     = 1'b0;
`endif

  assign imem_addr = redirect_valid ? redir_pc : pc_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign flush     = redirect_valid;

  // imem_addr already selects the redirect target, so one entry format serves both paths.
  always_comb begin
    pc_d           = pc_q;
    push           = 1'b0;
    push_dat.pc    = imem_addr;
    push_dat.instr = imem_rdata;
    if (redirect_valid) begin
      if (!redir_bad) begin
        push = 1'b1;
        pc_d = redir_pc + 32'd4;
      end
    end else if (running && ((count < CNT_W'(DEPTH)) || pop)) begin
      push = 1'b1;
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .count    (count),
    .head     (head)
  );

  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = out_valid ? (head.pc + 32'd4) : 32'd0;

endmodule
